vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA scan-out pixel fetch and a drawing/write client.
- Sits between the VGA timing/pixel pipeline and the framebuffer RAM.
- Display fetch has strict priority so scan-out never misses a pixel. Writes use idle RAM cycles through a req/ack handshake.
- Issues at most one RAM operation per cycle.

Parameters:
- ADDR_W, 19, framebuffer address width (640x480 = 307200 words).
- DATA_W, 3, pixel width (1 bit each R, G, B).
- WAIT_MAX, 1023, number of consecutive blocked write-request cycles before the starvation flag is set.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- rst_n  in  1  asynchronous active-low reset.
- disp_req  in  1  scan-out fetch request, single-cycle per pixel.
- disp_addr  in  ADDR_W  fetch address, valid with disp_req.
- disp_valid  out  1  fetched pixel valid, one-cycle pulse.
- disp_data  out  DATA_W  fetched pixel.
- wr_req  in  1  write request, held until wr_ack.
- wr_addr  in  ADDR_W  write address, stable while wr_req=1.
- wr_data  in  DATA_W  write pixel, stable while wr_req=1.
- wr_ack  out  1  write accepted, one-cycle pulse.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; sync read, valid the cycle after ram_en=1 with ram_we=0.
- wr_starved  out  1  sticky starvation flag.

Behaviour:
Reset:
- rst_n=0 asynchronously clears every output to 0: disp_valid, disp_data, wr_ack, ram_en, ram_we, ram_addr, ram_wdata, wr_starved.
- Also clears the state register (to IDLE), the read-pending pipeline bit, and the wait counter.

Registered outputs:
- All outputs are registered. No combinational path from any input to any output.

Grant, evaluated at each rising edge E:
- If disp_req=1: after E, ram_en=1, ram_we=0, ram_addr=disp_addr. State goes to RD. Any wr_req is deferred.
- Else if wr_req=1 and wr_ack=0: after E, ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1. State goes to WR.
- Else: ram_en=0, ram_we=0, wr_ack=0. State goes to IDLE. ram_addr and ram_wdata hold their last values.

Read path:
- The read-pending bit follows the RD grant.
- The RAM returns data after E+1.
- disp_valid=1 and disp_data=ram_rdata are registered at E+2.
- Fixed read latency is 2 cycles from disp_req sampled to disp_valid, fully pipelined: back-to-back disp_req every cycle gives disp_valid every cycle.
- disp_data holds its value when disp_valid=0.

Write handshake:
- wr_req sampled while wr_ack=1 is treated as already consumed and is not granted again.
- Maximum write throughput is 1 per 2 cycles.
- The requester may drop wr_req, or change address/data, in the cycle wr_ack=1.

Simultaneous requests:
- disp_req and wr_req together: read granted, write waits. The write is granted on the first edge with disp_req=0.

Starvation:
- The wait counter increments on each edge where wr_req=1 and no write is granted.
- It clears on a write grant or when wr_req=0, and saturates at WAIT_MAX.
- When the counter reaches WAIT_MAX, wr_starved goes to 1 and stays 1 until reset.
- Starvation does not change priority; the flag is diagnostic only.

Reset mid-operation:
- An in-flight read is discarded; no disp_valid is issued for it after release.
- An un-acked write is not performed; the requester must re-present it.
- The first grant after release occurs on the first edge with rst_n=1.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n=0 asynchronously between edges -> outputs clear immediately.
- Single read: RAM model preloaded addr 0x00010=3'b101; disp_req pulse at edge E -> ram_en=1, ram_we=0, ram_addr=0x00010 after E; disp_valid=1, disp_data=3'b101 after E+2 only.
- Single write: wr_req=1, wr_addr=0x12345, wr_data=3'b011 -> one wr_ack pulse, ram_we=1 with matching addr/data the same cycle. A subsequent read of 0x12345 returns 3'b011.
- Conflict and throughput:
  - disp_req=1 for 640 consecutive cycles while wr_req=1 -> zero writes during the burst; write acked on the first cycle after disp_req falls.
  - Continuous wr_req with no display traffic -> exactly one wr_ack every 2 cycles.
- Starvation: WAIT_MAX=8, disp_req held 1 and wr_req held 1 -> wr_starved=1 after the 8th blocked edge. It stays 1 after disp_req drops and the write completes; it clears only on reset.
- Reset mid-operation: assert rst_n=0 one cycle after a read grant -> no disp_valid for that read after release. Assert it while wr_req is pending un-acked -> RAM contents unchanged until the write is re-granted after release.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter: display fetch priority, write client on idle cycles
module vga_fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int WAIT_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wr_starved
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state, next_state;
  logic             rd_pend;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  // A write granted last edge (state WR, wr_ack high) is already consumed.
  always_comb begin
    next_state    = IDLE;
    wait_cnt_next = '0;
    if (disp_req)
      next_state = RD;
    else if (wr_req && state != WR)
      next_state = WR;
    if (wr_req && next_state != WR)
      wait_cnt_next = (wait_cnt == CNT_W'(WAIT_MAX)) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rd_pend    <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      wr_ack     <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      wr_starved <= 1'b0;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_cnt_next;
      ram_en     <= (next_state != IDLE);
      ram_we     <= (next_state == WR);
      wr_ack     <= (next_state == WR);
      if (next_state == RD) begin
        ram_addr <= disp_addr;
      end else if (next_state == WR) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end
      // RAM samples the read one edge after the grant; data is captured one edge later.
      rd_pend    <= (state == RD);
      disp_valid <= rd_pend;
      if (rd_pend)
        disp_data <= ram_rdata;
      if (wait_cnt_next == CNT_W'(WAIT_MAX))
        wr_starved <= 1'b1;
    end
  end

endmodule
